dma_sector_responder: RTL and testbench
=======================================

// Module: dma_sector_responder
// PURPOSE
// - Avalon-MM responder serving the DMA bridge's mem_read/mem_write initiator port.
// - Backs a one-sector (512 B) word buffer shared with the disk controller.
// - Generates mem_waitrequest and fixed-latency mem_readdatavalid.
// - Signals sector-complete events so the disk side can raise disk_result_ok.
// PARAMETERS
// - DEPTH_LOG2  7  buffer depth in 32-bit words (128 = one sector)
// - RD_LATENCY  2  accept-to-readdatavalid cycles, legal range 1..4
// PORTS
// - clk_sys           in   1   system clock; all logic on rising edge
// - reset_n           in   1   asynchronous, active-low reset
// - mem_address       in   32  byte address; bits [DEPTH_LOG2+1:2] index the buffer
// - mem_read          in   1   read request
// - mem_write         in   1   write request
// - mem_writedata     in   32  write data
// - mem_byteenable    in   4   per-byte write enable
// - mem_waitrequest   out  1   1 = request not accepted this cycle
// - mem_readdata      out  32  read data, valid with mem_readdatavalid
// - mem_readdatavalid out  1   read data strobe
// - dsk_lock          in   1   disk controller owns the buffer
// - dsk_addr          in   DEPTH_LOG2  disk-side word index
// - dsk_we            in   1   disk-side write, honoured only while dsk_lock=1
// - dsk_wdata         in   32  disk-side write data
// - dsk_rdata         out  32  disk-side read data, 1-cycle latency
// - sector_full       out  1   1-cycle pulse: DEPTH words written by the Avalon side
// - sector_drained    out  1   1-cycle pulse: DEPTH reads returned on the Avalon side
// - proto_err         out  1   sticky error flag; cleared only by reset
// - stat_rd_cnt       out  16  accepted-read count (optional feature)
// - stat_wr_cnt       out  16  accepted-write count (optional feature)
// BEHAVIOUR
// - Reset values: all outputs 0 except mem_waitrequest=1 while reset_n=0; read pipe, counters and proto_err cleared.
// - mem_waitrequest is combinational: ~reset_sync | dsk_lock | (mem_read & mem_write).
// - Accept condition: (mem_read | mem_write) & ~mem_waitrequest.
// - Simultaneous read+write: never accepted; proto_err is set.
// - Out-of-range address (any of bits [31:DEPTH_LOG2+2] or [1:0] nonzero):
//   - read is accepted and returns 32'h0;
//   - write is dropped;
//   - proto_err is set.
// - Read path: data returns exactly RD_LATENCY cycles after accept.
//   - Valid shift register; back-to-back accepts give back-to-back valid; order preserved.
//   - Write-first: a read accepted the cycle after a write to the same word returns the new data.
// - Write: byte lanes updated per mem_byteenable. byteenable=0 still counts as accepted, with no data change.
// - wr_cnt increments on every in-range accepted write.
//   - On reaching DEPTH-1 -> DEPTH it pulses sector_full and wraps to 0.
// - rd_cnt does the same on every in-range readdatavalid and pulses sector_drained.
// - dsk_lock rising edge: wr_cnt and rd_cnt reset to 0.
//   - Reads already in flight still complete and still count.
// - Dual-port RAM: Avalon side has priority on a same-cycle same-word write collision; dsk write is lost.
// - Async reset mid-read: in-flight reads are discarded; no readdatavalid after release.
// - reset_sync: two-flop synchroniser on reset release; waitrequest stays 1 until it deasserts.
// CONFIGURATION
// - Macro SECTOR_RESP_STATS_EN:
//   - defined: stat_rd_cnt/stat_wr_cnt are 16-bit saturating counters of accepted Avalon reads/writes, including out-of-range ones.
//   - undefined: both ports are tied to 0 and no counter logic is synthesised.
// TESTING
// - Write words 0..127 = index*0x01010101 (byteenable 4'hF), then read 0..127:
//   - data matches; sector_full pulses once after the 128th write;
//   - sector_drained pulses once after the 128th readdatavalid.
// - Read to byte addr 0x40 with RD_LATENCY=2: readdatavalid high exactly 2 cycles after accept.
//   - 4 back-to-back reads -> 4 consecutive valid cycles.
// - Write 0xAABBCCDD to word 5 with byteenable=4'b0101 over 0x11111111: readback is 0x11BB11DD.
// - Assert dsk_lock mid-burst: waitrequest=1 the same cycle, pending reads still return, counters cleared.
//   - dsk_we word 3 = 0x12345678; unlock; Avalon read of word 3 returns 0x12345678.
// - mem_read&mem_write together: waitrequest=1, nothing accepted, proto_err=1.
//   - Read at byte addr 0x200 returns 0 and keeps proto_err=1.
// - reset_n low 2 cycles after a read accept: no readdatavalid ever appears; waitrequest=1 until 2 cycles after release.

Source files
------------

// File: rtl/dma_sector_responder.sv
// Avalon-MM responder over a one-sector word buffer shared with the disk controller.
// Latency: reads return exactly RD_LATENCY cycles after accept; dsk_rdata 1 cycle after dsk_addr.
// Backpressure: mem_waitrequest held high until reset sync completes, while dsk_lock=1, or on read+write.
//
// Ports: clk_sys/reset_n (async active-low); mem_* Avalon-MM responder port;
//        dsk_* disk-side buffer port (writes honoured only while dsk_lock=1);
//        sector_full/sector_drained one-cycle event pulses (one cycle after the DEPTH-th event);
//        proto_err sticky protocol error; stat_rd_cnt/stat_wr_cnt accepted-request counters.
// Optional feature macro: SECTOR_RESP_STATS_EN (saturating stat counters; tied to 0 when undefined).
module dma_sector_responder #(
   parameter int DEPTH_LOG2 = 7,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [31:0]           mem_address,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [31:0]           mem_writedata,
   input  logic [3:0]            mem_byteenable,
   output logic                  mem_waitrequest,
   output logic [31:0]           mem_readdata,
   output logic                  mem_readdatavalid,
   input  logic                  dsk_lock,
   input  logic [DEPTH_LOG2-1:0] dsk_addr,
   input  logic                  dsk_we,
   input  logic [31:0]           dsk_wdata,
   output logic [31:0]           dsk_rdata,
   output logic                  sector_full,
   output logic                  sector_drained,
   output logic                  proto_err,
   output logic [15:0]           stat_rd_cnt,
   output logic [15:0]           stat_wr_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

   logic [1:0]            rst_sync;
   logic                  acc, rd_acc, wr_acc, av_wr, dsk_wr;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  lock_q, lock_rise;
   logic [DEPTH_LOG2-1:0] wr_cnt, rd_cnt, rd_base;
   logic                  rd_evt;

   logic [31:0]           mem [DEPTH];
   logic [RD_LATENCY-1:0] pipe_vld;
   logic [RD_LATENCY-1:0] pipe_inr;
   logic [31:0]           pipe_dat [RD_LATENCY];

   // Reset release is synchronised; requests are held off until both flops are set.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign mem_waitrequest = ~rst_sync[1] | dsk_lock | (mem_read & mem_write);
   assign acc      = (mem_read | mem_write) & ~mem_waitrequest;
   assign rd_acc   = acc & mem_read;
   assign wr_acc   = acc & mem_write;
   assign in_range = (mem_address[31:DEPTH_LOG2+2] == '0) && (mem_address[1:0] == 2'b00);
   assign idx      = mem_address[DEPTH_LOG2+1:2];
   assign av_wr    = wr_acc & in_range;

   // Avalon wins a same-word collision; the disk write is simply dropped.
   assign dsk_wr    = dsk_lock & dsk_we & ~(av_wr & (idx == dsk_addr));
   assign lock_rise = dsk_lock & ~lock_q;

   // Reads still in flight at a lock rising edge count from the freshly cleared value.
   assign rd_evt  = pipe_vld[RD_LATENCY-1] & pipe_inr[RD_LATENCY-1];
   assign rd_base = lock_rise ? '0 : rd_cnt;

   // Buffer and read data pipe carry no reset; pipe data is qualified by pipe_vld.
   // A read samples the array at its accept edge, so a write from the prior cycle is seen.
   always_ff @(posedge clk_sys) begin
      if (dsk_wr) mem[dsk_addr] <= dsk_wdata;
      if (av_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byteenable[b]) mem[idx][8*b +: 8] <= mem_writedata[8*b +: 8];
         end
      end
      if (rd_acc) pipe_dat[0] <= in_range ? mem[idx] : 32'h0;
      for (int i = 1; i < RD_LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld       <= '0;
         pipe_inr       <= '0;
         lock_q         <= 1'b0;
         wr_cnt         <= '0;
         rd_cnt         <= '0;
         sector_full    <= 1'b0;
         sector_drained <= 1'b0;
         proto_err      <= 1'b0;
         dsk_rdata      <= '0;
      end else begin
         pipe_vld[0] <= rd_acc;
         pipe_inr[0] <= rd_acc & in_range;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_inr[i] <= pipe_inr[i-1];
         end
         lock_q    <= dsk_lock;
         dsk_rdata <= mem[dsk_addr];

         // Writes cannot be accepted while locked, so a rising edge simply clears.
         sector_full <= 1'b0;
         if (lock_rise) begin
            wr_cnt <= '0;
         end else if (av_wr) begin
            wr_cnt      <= wr_cnt + 1'b1;
            sector_full <= (wr_cnt == LAST_IDX);
         end

         sector_drained <= 1'b0;
         if (rd_evt) begin
            rd_cnt         <= rd_base + 1'b1;
            sector_drained <= (rd_base == LAST_IDX);
         end else begin
            rd_cnt <= rd_base;
         end

         if ((mem_read & mem_write) | (acc & ~in_range)) proto_err <= 1'b1;
      end
   end

   assign mem_readdatavalid = pipe_vld[RD_LATENCY-1];
   assign mem_readdata      = pipe_vld[RD_LATENCY-1] ? pipe_dat[RD_LATENCY-1] : 32'h0;

`ifdef SECTOR_RESP_STATS_EN
   logic [15:0] stat_rd_q, stat_wr_q;

   // Out-of-range requests are accepted, so they count here too.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         stat_rd_q <= '0;
         stat_wr_q <= '0;
      end else begin
         if (rd_acc && stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 1'b1;
         if (wr_acc && stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 1'b1;
      end
   end

   assign stat_rd_cnt = stat_rd_q;
   assign stat_wr_cnt = stat_wr_q;
`else
   assign stat_rd_cnt = '0;
   assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_sector_responder.sv
// Bench for dma_sector_responder: directed scenarios plus random traffic, checked every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The reference keeps a word-array image, a queue of pending reads with due cycles and event counts.
module tb_dma_sector_responder;

   localparam int DL    = 7;
   localparam int L     = 2;
   localparam int DEPTH = 1 << DL;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic [31:0]   mem_address = '0;
   logic          mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0]   mem_writedata = '0;
   logic [3:0]    mem_byteenable = '0;
   logic          mem_waitrequest, mem_readdatavalid;
   logic [31:0]   mem_readdata;
   logic          dsk_lock = 1'b0, dsk_we = 1'b0;
   logic [DL-1:0] dsk_addr = '0;
   logic [31:0]   dsk_wdata = '0, dsk_rdata;
   logic          sector_full, sector_drained, proto_err;
   logic [15:0]   stat_rd_cnt, stat_wr_cnt;

   always #5 clk_sys = ~clk_sys;

   dma_sector_responder #(.DEPTH_LOG2(DL), .RD_LATENCY(L)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid),
      .dsk_lock(dsk_lock), .dsk_addr(dsk_addr), .dsk_we(dsk_we), .dsk_wdata(dsk_wdata),
      .dsk_rdata(dsk_rdata), .sector_full(sector_full), .sector_drained(sector_drained),
      .proto_err(proto_err), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [31:0] dat;
      bit          known;
      bit          inr;
   } rd_t;

   logic [31:0] mm [DEPTH];
   bit          mk [DEPTH];
   rd_t         rq [$];
   logic [31:0] got_q [$];
   int          gotc_q [$];
   int          nc = 0, rs_edges = 0, wcnt = 0, rcnt = 0, s_rd = 0, s_wr = 0;
   int          last_acc = 0, full_seen = 0, drn_seen = 0;
   bit          prev_lock = 0, e_full = 0, e_drn = 0, e_perr = 0, e_dsk_k = 1;
   logic [31:0] e_dsk = '0;

   function automatic bit addr_ok(input logic [31:0] a);
      return (a[31:DL+2] == '0) && (a[1:0] == 2'b00);
   endfunction

   always @(negedge clk_sys) begin : mdl
      bit  ev, vld_inr, wreq, acc, inr, rise;
      int  ix;
      rd_t e;
      nc++;
      if (!reset_n) begin
         chk("rst_waitreq", mem_waitrequest, 1);
         chk("rst_rdvalid", mem_readdatavalid, 0);
         chk("rst_rddata", mem_readdata, 0);
         chk("rst_full", sector_full, 0);
         chk("rst_drained", sector_drained, 0);
         chk("rst_proto", proto_err, 0);
         chk("rst_dsk_rdata", dsk_rdata, 0);
         chk("rst_stat_rd", stat_rd_cnt, 0);
         chk("rst_stat_wr", stat_wr_cnt, 0);
         rq.delete();
         rs_edges = 0; wcnt = 0; rcnt = 0; s_rd = 0; s_wr = 0;
         prev_lock = 0; e_full = 0; e_drn = 0; e_perr = 0; e_dsk = '0; e_dsk_k = 1;
      end else begin
         wreq = (rs_edges < 2) || dsk_lock || (mem_read && mem_write);
         chk("waitrequest", mem_waitrequest, wreq);
         ev = (rq.size() > 0) && (rq[0].due == nc);
         chk("readdatavalid", mem_readdatavalid, ev);
         vld_inr = 0;
         if (ev) begin
            e = rq.pop_front();
            vld_inr = e.inr;
            if (e.known) chk("readdata", mem_readdata, e.dat);
         end else begin
            chk("readdata_idle", mem_readdata, 0);
         end
         if (mem_readdatavalid) begin
            got_q.push_back(mem_readdata);
            gotc_q.push_back(nc);
         end
         if (sector_full) full_seen++;
         if (sector_drained) drn_seen++;
         chk("sector_full", sector_full, e_full);
         chk("sector_drained", sector_drained, e_drn);
         chk("proto_err", proto_err, e_perr);
         if (e_dsk_k) chk("dsk_rdata", dsk_rdata, e_dsk);
`ifdef SECTOR_RESP_STATS_EN
         chk("stat_rd", stat_rd_cnt, s_rd);
         chk("stat_wr", stat_wr_cnt, s_wr);
`else
         chk("stat_rd_tied", stat_rd_cnt, 0);
         chk("stat_wr_tied", stat_wr_cnt, 0);
`endif
         // effects of this cycle's inputs at the coming rising edge
         acc  = (mem_read || mem_write) && !wreq;
         inr  = addr_ok(mem_address);
         ix   = int'(mem_address[DL+1:2]);
         rise = dsk_lock && !prev_lock;
         e_dsk   = mm[dsk_addr];
         e_dsk_k = mk[dsk_addr];
         if (acc && mem_read) begin
            e.due   = nc + L;
            e.inr   = inr;
            e.dat   = inr ? mm[ix] : 32'h0;
            e.known = inr ? mk[ix] : 1'b1;
            rq.push_back(e);
            last_acc = nc;
            if (s_rd < 65535) s_rd++;
         end
         if (rise) begin
            rcnt = 0;
            wcnt = 0;
         end
         e_drn = 0;
         if (vld_inr) begin
            rcnt++;
            if (rcnt == DEPTH) begin rcnt = 0; e_drn = 1; end
         end
         e_full = 0;
         if (acc && mem_write) begin
            if (s_wr < 65535) s_wr++;
            if (inr) begin
               wcnt++;
               if (wcnt == DEPTH) begin wcnt = 0; e_full = 1; end
               for (int b = 0; b < 4; b++)
                  if (mem_byteenable[b]) mm[ix][8*b +: 8] = mem_writedata[8*b +: 8];
               if (mem_byteenable == 4'hF) mk[ix] = 1;
            end
         end
         if ((mem_read && mem_write) || (acc && !inr)) e_perr = 1;
         if (dsk_lock && dsk_we && !(acc && mem_write && inr && ix == int'(dsk_addr))) begin
            mm[dsk_addr] = dsk_wdata;
            mk[dsk_addr] = 1;
         end
         prev_lock = dsk_lock;
         if (rs_edges < 2) rs_edges++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic av_xfer(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
      int n = 0;
      mem_read = !is_wr; mem_write = is_wr;
      mem_address = a; mem_writedata = d; mem_byteenable = be;
      @(negedge clk_sys);
      while (mem_waitrequest && n < 100) begin @(negedge clk_sys); n++; end
      if (mem_waitrequest) chk("accept_timeout", mem_waitrequest, 0);
      @(posedge clk_sys); #1;
   endtask

   task automatic av_idle();
      mem_read = 0; mem_write = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic clr_got();
      got_q.delete();
      gotc_q.delete();
   endtask

   task automatic wait_got(output logic [31:0] d, output int c);
      int n = 0;
      while (got_q.size() == 0 && n < 20) begin @(posedge clk_sys); #1; n++; end
      if (got_q.size() == 0) begin
         chk("read_return_timeout", got_q.size(), 1);
         d = '0; c = 0;
      end else begin
         d = got_q.pop_front();
         c = gotc_q.pop_front();
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] d;
      int          c;
      @(negedge clk_sys);
      chk("reset_waitreq_lit", mem_waitrequest, 1);
      cycles(3);
      reset_n = 1;
      cycles(3);

      // full sector write then drain
      full_seen = 0; drn_seen = 0;
      for (int i = 0; i < DEPTH; i++) av_xfer(1, i * 4, i * 32'h01010101, 4'hF);
      av_idle();
      for (int i = 0; i < DEPTH; i++) av_xfer(0, i * 4, 0, 4'h0);
      av_idle();
      cycles(6);
      chk("sector_full_once", full_seen, 1);
      chk("sector_drained_once", drn_seen, 1);

      // latency and back-to-back reads
      clr_got();
      av_xfer(0, 32'h40, 0, 4'h0);
      av_idle();
      wait_got(d, c);
      chk("latency_0x40", c - last_acc, 2);
      chk("data_0x40", d, 32'h10101010);
      cycles(2);
      clr_got();
      for (int k = 0; k < 4; k++) av_xfer(0, k * 4, 0, 4'h0);
      av_idle();
      cycles(8);
      chk("b2b_count", got_q.size(), 4);
      if (got_q.size() == 4)
         for (int k = 1; k < 4; k++) chk("b2b_consecutive", gotc_q[k] - gotc_q[k-1], 1);

      // byte enables
      av_xfer(1, 32'h14, 32'h11111111, 4'hF);
      av_xfer(1, 32'h14, 32'hAABBCCDD, 4'b0101);
      clr_got();
      av_xfer(0, 32'h14, 0, 4'h0);
      av_idle();
      wait_got(d, c);
      chk("byteenable_merge", d, 32'h11BB11DD);
      cycles(2);

      // disk lock during a burst
      clr_got();
      for (int k = 0; k < 3; k++) av_xfer(0, k * 4, 0, 4'h0);
      dsk_lock = 1; mem_read = 1; mem_address = 32'hC;
      @(negedge clk_sys);
      chk("lock_waitreq", mem_waitrequest, 1);
      @(posedge clk_sys); #1;
      av_idle();
      cycles(5);
      chk("lock_pending_reads", got_q.size(), 3);
      if (got_q.size() == 3) chk("lock_pending_data", got_q[1], 32'h01010101);
      dsk_addr = 3; dsk_wdata = 32'h12345678; dsk_we = 1;
      cycles(1);
      dsk_we = 0;
      cycles(1);
      @(negedge clk_sys);
      chk("dsk_rdata_lit", dsk_rdata, 32'h12345678);
      @(posedge clk_sys); #1;
      dsk_lock = 0;
      clr_got();
      av_xfer(0, 32'hC, 0, 4'h0);
      av_idle();
      wait_got(d, c);
      chk("dsk_write_seen_by_avalon", d, 32'h12345678);
      cycles(2);

      // read+write together, then out-of-range read
      mem_read = 1; mem_write = 1; mem_address = 32'h0; mem_writedata = 32'hDEADBEEF;
      mem_byteenable = 4'hF;
      @(negedge clk_sys);
      chk("rdwr_waitreq", mem_waitrequest, 1);
      @(posedge clk_sys); #1;
      av_idle();
      @(negedge clk_sys);
      chk("proto_err_set", proto_err, 1);
      @(posedge clk_sys); #1;
      clr_got();
      av_xfer(0, 32'h200, 0, 4'h0);
      av_idle();
      wait_got(d, c);
      chk("oor_read_zero", d, 32'h0);
      chk("proto_err_sticky", proto_err, 1);
      cycles(2);

      // reset while a read is in flight
      clr_got();
      av_xfer(0, 32'h40, 0, 4'h0);
      av_idle();
      reset_n = 0;
      cycles(2);
      reset_n = 1;
      @(negedge clk_sys);
      chk("release_waitreq_c0", mem_waitrequest, 1);
      @(negedge clk_sys);
      chk("release_waitreq_c1", mem_waitrequest, 1);
      @(negedge clk_sys);
      chk("release_waitreq_c2", mem_waitrequest, 0);
      cycles(8);
      chk("no_valid_after_reset", got_q.size(), 0);

      // random traffic
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int r;
         r = $urandom_range(0, 99);
         mem_read  = (r < 40) || (r >= 98);
         mem_write = (r >= 40 && r < 75) || (r >= 98);
         if ($urandom_range(0, 9) != 0) mem_address = {23'h0, 7'($urandom), 2'b00};
         else                           mem_address = $urandom;
         mem_writedata  = $urandom;
         mem_byteenable = 4'($urandom);
         if (dsk_lock) begin
            if ($urandom_range(0, 19) == 0) dsk_lock = 0;
         end else begin
            if ($urandom_range(0, 399) == 0) dsk_lock = 1;
         end
         dsk_we    = 1'($urandom);
         dsk_addr  = 7'($urandom);
         dsk_wdata = $urandom;
         cycles(1);
      end
      av_idle();
      dsk_lock = 0;
      dsk_we = 0;
      cycles(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
